// File: rtl/fpgc_int_pkg.sv
// ---------------------------------------------------------------------------
// fpgc_int_pkg
// Shared definitions for the interrupt controller: source count, register
// map addresses, FSM state encoding, reset warm-up length and the fixed
// priority encoder used to pick the next source to serve.
// ---------------------------------------------------------------------------
package fpgc_int_pkg;

   localparam int NUM_SRC = 8;
   localparam int ID_W    = 3;

   // Register map (cfg_addr)
   localparam logic [1:0] ADDR_PENDING  = 2'd0;
   localparam logic [1:0] ADDR_MASK     = 2'd1;
   localparam logic [1:0] ADDR_ACTIVE   = 2'd2;
   localparam logic [1:0] ADDR_POLARITY = 2'd3;

   // Edge detection stays disabled until the sync chain and edge register
   // all hold samples taken after reset release (three clock edges).
   localparam logic [1:0] ARM_DONE = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   // Lowest set index wins: bit 0 has the highest priority.
   function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_SRC-1:0] vec);
      logic [ID_W-1:0] idx;
      idx = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (vec[i]) idx = ID_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/int_sync_edge.sv
// ---------------------------------------------------------------------------
// int_sync_edge
// One interrupt source: 2-flop synchronizer, edge register and
// polarity-selected edge detector.
//   clk, nreset : clock, asynchronous active-low reset
//   irq_i       : raw (possibly asynchronous) interrupt level
//   pol_i       : 0 = detect rising edge, 1 = detect falling edge
//   arm_i       : detection enable (low during post-reset warm-up)
//   edge_o      : single-cycle pulse when the selected edge is seen
// ---------------------------------------------------------------------------
module int_sync_edge (
   input  logic clk,
   input  logic nreset,
   input  logic irq_i,
   input  logic pol_i,
   input  logic arm_i,
   output logic edge_o
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour, forming a real shift chain.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= irq_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // XOR with polarity folds the falling-edge case onto a rising-edge test.
   assign edge_o = arm_i & (sync2_q ^ pol_i) & ~(prev_q ^ pol_i);

endmodule

// File: rtl/int_controller.sv
// ---------------------------------------------------------------------------
// int_controller
// Edge-triggered interrupt controller with per-source polarity, mask and
// fixed priority, plus a small CPU-visible register file.
//   clk, nreset        : clock, asynchronous active-low reset
//   irq_in             : raw interrupt levels (one bit per source)
//   cfg_we/addr/d      : register write port (0 PENDING W1C, 1 MASK,
//                        2 ACTIVE read-only, 3 POLARITY)
//   cfg_q              : registered read data for cfg_addr
//   int_req / int_id   : request and source index to the CPU
//   int_ack            : one-cycle acknowledge from the CPU
// ---------------------------------------------------------------------------
module int_controller #(
   parameter int NUM_SRC = fpgc_int_pkg::NUM_SRC
) (
   input  logic               clk,
   input  logic               nreset,
   input  logic [NUM_SRC-1:0] irq_in,
   input  logic               cfg_we,
   input  logic [1:0]         cfg_addr,
   input  logic [31:0]        cfg_d,
   output logic [31:0]        cfg_q,
   output logic               int_req,
   output logic [2:0]         int_id,
   input  logic               int_ack
);

   import fpgc_int_pkg::*;

   logic [NUM_SRC-1:0] pending_q, pending_d;
   logic [NUM_SRC-1:0] mask_q, mask_d;
   logic [NUM_SRC-1:0] pol_q, pol_d;
   logic [NUM_SRC-1:0] edge_det;
   logic [NUM_SRC-1:0] w1c_clr;
   logic [NUM_SRC-1:0] ack_clr;
   logic [1:0]         arm_q, arm_d;
   logic               arm;
   logic [31:0]        rdata_d, rdata_q;
   state_e             state_q;
   logic               int_req_q;
   logic [ID_W-1:0]    int_id_q;
   logic [31:NUM_SRC]  unused_cfg_d;

   assign unused_cfg_d = cfg_d[31:NUM_SRC];

   assign arm   = (arm_q == ARM_DONE);
   assign arm_d = arm ? arm_q : arm_q + 2'd1;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      int_sync_edge u_sync_edge (
         .clk    (clk),
         .nreset (nreset),
         .irq_i  (irq_in[i]),
         .pol_i  (pol_q[i]),
         .arm_i  (arm),
         .edge_o (edge_det[i])
      );
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // through the case statements can infer a latch.
      w1c_clr = '0;
      ack_clr = '0;
      mask_d  = mask_q;
      pol_d   = pol_q;
      rdata_d = '0;

      if (cfg_we) begin
         case (cfg_addr)
            ADDR_PENDING:  w1c_clr = cfg_d[NUM_SRC-1:0];
            ADDR_MASK:     mask_d  = cfg_d[NUM_SRC-1:0];
            ADDR_POLARITY: pol_d   = cfg_d[NUM_SRC-1:0];
            default:       ;
         endcase
      end

      // An ack only clears the source latched at entry to REQ; if software
      // already cleared it, this is a no-op.
      if (state_q == ST_REQ && int_ack) ack_clr[int_id_q] = 1'b1;

      // A new edge beats any clear landing on the same bit in the same cycle.
      pending_d = (pending_q & ~(w1c_clr | ack_clr)) | edge_det;

      case (cfg_addr)
         ADDR_PENDING:  rdata_d[NUM_SRC-1:0] = pending_q;
         ADDR_MASK:     rdata_d[NUM_SRC-1:0] = mask_q;
         ADDR_ACTIVE: begin
            rdata_d[7]        = int_req_q;
            rdata_d[ID_W-1:0] = int_id_q;
         end
         ADDR_POLARITY: rdata_d[NUM_SRC-1:0] = pol_q;
         default:       ;
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         pending_q <= '0;
         mask_q    <= '0;
         pol_q     <= '0;
         arm_q     <= '0;
         rdata_q   <= '0;
      end else begin
         pending_q <= pending_d;
         mask_q    <= mask_d;
         pol_q     <= pol_d;
         arm_q     <= arm_d;
         rdata_q   <= rdata_d;
      end
   end

   // Request FSM with registered outputs; int_id is latched on IDLE -> REQ
   // and stays put until the next request is taken.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q   <= ST_IDLE;
         int_req_q <= 1'b0;
         int_id_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (|(pending_q & mask_q)) begin
                  state_q   <= ST_REQ;
                  int_req_q <= 1'b1;
                  int_id_q  <= lowest_set(pending_q & mask_q);
               end
            end
            ST_REQ: begin
               if (int_ack) begin
                  state_q   <= ST_HOLD;
                  int_req_q <= 1'b0;
               end
            end
            ST_HOLD: state_q <= ST_IDLE;
            default: begin
               state_q   <= ST_IDLE;
               int_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign cfg_q   = rdata_q;
   assign int_req = int_req_q;
   assign int_id  = int_id_q;

endmodule

// File: tb/tb_int_controller.sv
// ---------------------------------------------------------------------------
// tb_int_controller
// Self-checking bench for int_controller: a cycle table for the basic
// request/ack and masked-pending flows, hand sequences for priority,
// polarity, clear/set collision and mid-request reset, and a randomized
// run against a behavioural model.
// ---------------------------------------------------------------------------
module tb_int_controller;

   logic        clk = 1'b0;
   logic        nreset = 1'b0;
   logic [7:0]  irq_in = '0;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_addr = '0;
   logic [31:0] cfg_d = '0;
   logic [31:0] cfg_q;
   logic        int_req;
   logic [2:0]  int_id;
   logic        int_ack = 1'b0;

   int checks = 0;
   int errors = 0;

   always #20 clk = ~clk;

   int_controller #(.NUM_SRC(8)) dut (
      .clk      (clk),
      .nreset   (nreset),
      .irq_in   (irq_in),
      .cfg_we   (cfg_we),
      .cfg_addr (cfg_addr),
      .cfg_d    (cfg_d),
      .cfg_q    (cfg_q),
      .int_req  (int_req),
      .int_id   (int_id),
      .int_ack  (int_ack)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
      cfg_we = 1'b1;
      cfg_addr = a;
      cfg_d = d;
      tick();
      cfg_we = 1'b0;
      cfg_d = '0;
   endtask

   // Returns the register value as it stood when the call was made.
   task automatic cfg_read(input logic [1:0] a, output logic [31:0] v);
      cfg_addr = a;
      tick();
      v = cfg_q;
   endtask

   task automatic apply_reset();
      nreset = 1'b0;
      irq_in = '0;
      cfg_we = 1'b0;
      cfg_addr = '0;
      cfg_d = '0;
      int_ack = 1'b0;
      repeat (2) tick();
      nreset = 1'b1;
      repeat (6) tick();
   endtask

   task automatic wait_req(input string name, input int budget);
      int n;
      n = 0;
      while (!int_req && n < budget) begin
         tick();
         n++;
      end
      check({name, " int_req within budget"}, 32'(int_req), 32'd1);
   endtask

   // ------------------------------------------------------------------
   // Behavioural model: an edge counts when the input seen 2 cycles ago
   // differs from the one seen 3 cycles ago and ends at the level the
   // polarity selects; only samples taken after reset release count.
   // ------------------------------------------------------------------
   logic [7:0] m_pend, m_mask, m_pol, m_q8;
   logic       m_req, m_hold;
   logic [2:0] m_id;
   logic [7:0] m_hist[$];

   function automatic void model_clear();
      m_pend = '0;
      m_mask = '0;
      m_pol  = '0;
      m_q8   = '0;
      m_req  = 1'b0;
      m_hold = 1'b0;
      m_id   = '0;
      m_hist.delete();
   endfunction

   function automatic void model_edge();
      logic [7:0] older, newer, edges, clr, served, rd;
      edges = '0;
      m_hist.push_back(irq_in);
      if (m_hist.size() > 4) void'(m_hist.pop_front());
      if (m_hist.size() == 4) begin
         older = m_hist[0];
         newer = m_hist[1];
         for (int i = 0; i < 8; i++)
            if (older[i] != newer[i] && newer[i] == !m_pol[i]) edges[i] = 1'b1;
      end

      case (cfg_addr)
         2'd0:    rd = m_pend;
         2'd1:    rd = m_mask;
         2'd2:    rd = {m_req, 4'b0000, m_id};
         default: rd = m_pol;
      endcase

      clr = '0;
      if (cfg_we && cfg_addr == 2'd0) clr = cfg_d[7:0];
      if (m_req && int_ack) clr[m_id] = 1'b1;
      served = m_pend & m_mask;

      if (m_hold) begin
         m_hold = 1'b0;
      end else if (m_req) begin
         if (int_ack) begin
            m_req  = 1'b0;
            m_hold = 1'b1;
         end
      end else if (served != 0) begin
         m_req = 1'b1;
         for (int i = 0; i < 8; i++) begin
            if (served[i]) begin
               m_id = 3'(i);
               break;
            end
         end
      end

      m_pend = (m_pend & ~clr) | edges;
      if (cfg_we && cfg_addr == 2'd1) m_mask = cfg_d[7:0];
      if (cfg_we && cfg_addr == 2'd3) m_pol  = cfg_d[7:0];
      m_q8 = rd;
   endfunction

   // ------------------------------------------------------------------
   // Cycle table: one row per clock, expected outputs after that edge.
   // ------------------------------------------------------------------
   typedef struct {
      logic       we;
      logic [1:0] addr;
      logic [7:0] d;
      logic [7:0] irq;
      logic       ack;
      logic       exp_req;
      logic [2:0] exp_id;
      logic [7:0] exp_q;
   } vec_t;

   vec_t vecs[18];

   initial begin
      logic [31:0] v;

      // MASK=0x01, source 0 rises, request, ack
      vecs[0]  = '{1'b1, 2'd1, 8'h01, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00};
      vecs[1]  = '{1'b0, 2'd1, 8'h00, 8'h01, 1'b0, 1'b0, 3'd0, 8'h01};
      vecs[2]  = '{1'b0, 2'd0, 8'h00, 8'h01, 1'b0, 1'b0, 3'd0, 8'h00};
      vecs[3]  = '{1'b0, 2'd0, 8'h00, 8'h01, 1'b0, 1'b0, 3'd0, 8'h00};
      vecs[4]  = '{1'b0, 2'd0, 8'h00, 8'h01, 1'b0, 1'b1, 3'd0, 8'h01};
      vecs[5]  = '{1'b0, 2'd2, 8'h00, 8'h01, 1'b1, 1'b0, 3'd0, 8'h80};
      vecs[6]  = '{1'b0, 2'd0, 8'h00, 8'h01, 1'b0, 1'b0, 3'd0, 8'h00};
      vecs[7]  = '{1'b0, 2'd2, 8'h00, 8'h01, 1'b0, 1'b0, 3'd0, 8'h00};
      // MASK=0, source 3 rises and stays pending; unmasking raises int_req
      vecs[8]  = '{1'b1, 2'd1, 8'h00, 8'h09, 1'b0, 1'b0, 3'd0, 8'h01};
      vecs[9]  = '{1'b0, 2'd1, 8'h00, 8'h09, 1'b0, 1'b0, 3'd0, 8'h00};
      vecs[10] = '{1'b0, 2'd0, 8'h00, 8'h09, 1'b0, 1'b0, 3'd0, 8'h00};
      vecs[11] = '{1'b0, 2'd0, 8'h00, 8'h09, 1'b0, 1'b0, 3'd0, 8'h08};
      vecs[12] = '{1'b1, 2'd1, 8'h08, 8'h09, 1'b0, 1'b0, 3'd0, 8'h00};
      vecs[13] = '{1'b0, 2'd2, 8'h00, 8'h09, 1'b0, 1'b1, 3'd3, 8'h00};
      vecs[14] = '{1'b0, 2'd2, 8'h00, 8'h09, 1'b0, 1'b1, 3'd3, 8'h83};
      vecs[15] = '{1'b0, 2'd0, 8'h00, 8'h09, 1'b1, 1'b0, 3'd3, 8'h08};
      vecs[16] = '{1'b0, 2'd0, 8'h00, 8'h09, 1'b0, 1'b0, 3'd3, 8'h00};
      vecs[17] = '{1'b0, 2'd3, 8'h00, 8'h09, 1'b1, 1'b0, 3'd3, 8'h00};

      // Reset state
      #5;
      check("reset int_req", 32'(int_req), 32'd0);
      check("reset int_id", 32'(int_id), 32'd0);
      check("reset cfg_q", cfg_q, 32'd0);

      apply_reset();
      for (int i = 0; i < 18; i++) begin
         cfg_we   = vecs[i].we;
         cfg_addr = vecs[i].addr;
         cfg_d    = {24'h0, vecs[i].d};
         irq_in   = vecs[i].irq;
         int_ack  = vecs[i].ack;
         tick();
         check($sformatf("vec%0d int_req", i), 32'(int_req), 32'(vecs[i].exp_req));
         check($sformatf("vec%0d int_id", i), 32'(int_id), 32'(vecs[i].exp_id));
         check($sformatf("vec%0d cfg_q", i), cfg_q, {24'h0, vecs[i].exp_q});
      end
      cfg_we = 1'b0;
      int_ack = 1'b0;

      // Two sources in the same cycle: lower index first, then the other
      apply_reset();
      cfg_write(2'd1, 32'hFF);
      irq_in = 8'h14;
      wait_req("two-source", 10);
      check("two-source first id", 32'(int_id), 32'd2);
      cfg_addr = 2'd0;
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      check("two-source req drop", 32'(int_req), 32'd0);
      check("two-source pending before ack", cfg_q, 32'h14);
      tick();
      check("two-source hold req", 32'(int_req), 32'd0);
      check("two-source pending after ack", cfg_q, 32'h10);
      tick();
      check("two-source second req", 32'(int_req), 32'd1);
      check("two-source second id", 32'(int_id), 32'd4);
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      check("two-source second drop", 32'(int_req), 32'd0);
      tick();
      check("two-source pending empty", cfg_q, 32'h00);

      // Falling-edge polarity on source 5
      apply_reset();
      cfg_write(2'd3, 32'h20);
      irq_in = 8'h20;
      repeat (5) tick();
      cfg_read(2'd0, v);
      check("polarity rise ignored", v, 32'h00);
      cfg_read(2'd3, v);
      check("polarity readback", v, 32'h20);
      irq_in = 8'h00;
      repeat (5) tick();
      cfg_read(2'd0, v);
      check("polarity fall sets", v, 32'h20);

      // W1C landing on the same edge that sets the bit: set wins
      apply_reset();
      irq_in = 8'h02;
      tick();
      tick();
      cfg_write(2'd0, 32'h02);
      cfg_read(2'd0, v);
      check("w1c collision set wins", v, 32'h02);
      cfg_write(2'd0, 32'h02);
      cfg_read(2'd0, v);
      check("w1c clears", v, 32'h00);

      // Reset in the middle of a request with all inputs held high
      apply_reset();
      cfg_write(2'd1, 32'hFF);
      irq_in = 8'hFF;
      wait_req("reset-mid", 10);
      cfg_addr = 2'd2;
      tick();
      check("reset-mid active before reset", cfg_q, 32'h80);
      #5;
      nreset = 1'b0;
      #1;
      check("reset-mid int_req drops", 32'(int_req), 32'd0);
      check("reset-mid cfg_q cleared", cfg_q, 32'd0);
      tick();
      tick();
      nreset = 1'b1;
      cfg_addr = 2'd0;
      for (int k = 0; k < 5; k++) begin
         tick();
         check($sformatf("reset-mid pending cycle %0d", k), cfg_q, 32'd0);
         check($sformatf("reset-mid int_req cycle %0d", k), 32'(int_req), 32'd0);
      end

      // Randomized run against the model
      nreset = 1'b0;
      irq_in = '0;
      cfg_we = 1'b0;
      cfg_addr = '0;
      cfg_d = '0;
      int_ack = 1'b0;
      tick();
      tick();
      model_clear();
      nreset = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         cfg_we   = ($urandom_range(0, 3) == 0);
         cfg_addr = 2'($urandom_range(0, 3));
         cfg_d    = $urandom;
         for (int b = 0; b < 8; b++)
            if ($urandom_range(0, 7) == 0) irq_in[b] = ~irq_in[b];
         int_ack  = ($urandom_range(0, 2) == 0);
         model_edge();
         tick();
         check($sformatf("rand%0d int_req", c), 32'(int_req), 32'(m_req));
         check($sformatf("rand%0d int_id", c), 32'(int_id), 32'(m_id));
         check($sformatf("rand%0d cfg_q", c), cfg_q, {24'h0, m_q8});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
